// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: command table entry layout, op codes and sequencer states
package i2c_seq_pkg;
    localparam int ENTRY_W = 25;
    localparam int OP_HI   = 24;
    localparam int OP_LO   = 23;
    localparam int CHIP_HI = 22;
    localparam int CHIP_LO = 16;
    localparam int REG_HI  = 15;
    localparam int REG_LO  = 8;
    localparam int VAL_HI  = 7;
    localparam int VAL_LO  = 0;
    typedef enum logic [1:0] {OP_WRITE, OP_READ_CHECK, OP_DELAY, OP_END} op_t;
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, ISSUE, WAIT_START, WAIT_DONE, EVAL, DELAY, HOST_ISSUE, FINISH
    } state_t;
    function automatic logic [ENTRY_W-1:0] mk_entry(op_t op, logic [6:0] chip, logic [7:0] r, logic [7:0] v);
        return {op, chip, r, v};
    endfunction
endpackage

// File: rtl/i2c_init_rom.sv
// i2c_init_rom: HDMI transmitter (ADV7513 @0x39) init table, registered read.
module i2c_init_rom
    import i2c_seq_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic               clk,
    input  logic [AW-1:0]      addr,
    output logic [ENTRY_W-1:0] data
);
    logic [ENTRY_W-1:0] rom_d;
    // power up, wait for hot-plug/monitor sense, settle 2 ms, then video/HDMI setup
    always_comb begin
        case (int'(addr))
            0:       rom_d = mk_entry(OP_WRITE,      7'h39, 8'h41, 8'h10);
            1:       rom_d = mk_entry(OP_WRITE,      7'h39, 8'h98, 8'h03);
            2:       rom_d = mk_entry(OP_READ_CHECK, 7'h39, 8'h42, 8'h60);
            3:       rom_d = mk_entry(OP_DELAY,      7'h00, 8'h00, 8'h02);
            4:       rom_d = mk_entry(OP_WRITE,      7'h39, 8'h9A, 8'hE0);
            5:       rom_d = mk_entry(OP_WRITE,      7'h39, 8'h9C, 8'h30);
            6:       rom_d = mk_entry(OP_WRITE,      7'h39, 8'h9D, 8'h61);
            7:       rom_d = mk_entry(OP_WRITE,      7'h39, 8'hA2, 8'hA4);
            8:       rom_d = mk_entry(OP_WRITE,      7'h39, 8'hA3, 8'hA4);
            9:       rom_d = mk_entry(OP_WRITE,      7'h39, 8'hE0, 8'hD0);
            10:      rom_d = mk_entry(OP_WRITE,      7'h39, 8'hAF, 8'h06);
            default: rom_d = mk_entry(OP_END,        7'h00, 8'h00, 8'h00);
        endcase
    end
    always_ff @(posedge clk) data <= rom_d;
endmodule

// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: walks the HDMI init table over the shared I2C register block
// and lends that block to a host request port whenever the sequence is idle.
module i2c_init_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int TABLE_DEPTH = 64,
    parameter int DELAY_UNIT  = 27_000,
    parameter int MAX_RETRY   = 3,
    parameter int POLL_LIMIT  = 255,
    parameter int AUTO_START  = 1,
    localparam int IDX_W      = $clog2(TABLE_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             init_done,
    output logic             error,
    output logic [IDX_W-1:0] error_index,
    input  logic             host_req,
    input  logic             host_is_read,
    input  logic [6:0]       host_chip_addr,
    input  logic [7:0]       host_reg_addr,
    input  logic [7:0]       host_value,
    output logic             host_ack,
    output logic [7:0]       host_rdata,
    output logic             host_nack,
    output logic [6:0]       i2c_chip_addr,
    output logic [7:0]       i2c_reg_addr,
    output logic [7:0]       i2c_value,
    output logic             i2c_enable,
    output logic             i2c_is_read,
    input  logic [7:0]       i2c_data,
    input  logic             i2c_done,
    input  logic             i2c_ack_error
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(TABLE_DEPTH - 1);
    localparam logic [15:0] RETRY_MAX = 16'(MAX_RETRY);
    localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);
    localparam logic [31:0] UNIT = 32'(DELAY_UNIT);
    state_t state, nxt, reissue;
    op_t op;
    logic [IDX_W-1:0] index;
    logic [ENTRY_W-1:0] ent;
    logic [15:0] retry, poll;
    logic [31:0] dly;
    logic [1:0] tmo;
    logic [7:0] rdata_q;
    logic nack_q, host_mode, auto_pend, go, adv, fail, retry_inc, poll_inc;

    i2c_init_rom #(.AW(IDX_W)) u_rom (.clk(clk), .addr(index), .data(ent));

    assign op = op_t'(ent[OP_HI:OP_LO]);
    assign go = start || auto_pend;
    // the I2C block only accepts a command while done is high; otherwise wait in DECODE
    assign reissue = i2c_done ? ISSUE : DECODE;
    assign busy = state != IDLE;
    assign i2c_enable = state == ISSUE || state == HOST_ISSUE;
    assign host_ack = state == EVAL && host_mode;
    assign host_rdata = host_ack ? rdata_q : 8'h00;
    assign host_nack = host_ack && nack_q;

    always_comb begin
        nxt = state;
        adv = 1'b0;
        fail = 1'b0;
        retry_inc = 1'b0;
        poll_inc = 1'b0;
        case (state)
            IDLE:              nxt = go ? FETCH : (host_req && i2c_done) ? HOST_ISSUE : IDLE;
            FETCH:             nxt = DECODE;
            DECODE:            nxt = op == OP_END ? FINISH : op == OP_DELAY ? DELAY : reissue;
            ISSUE, HOST_ISSUE: nxt = WAIT_START;
            WAIT_START:        nxt = !i2c_done ? WAIT_DONE : tmo == 2'd3 ? EVAL : WAIT_START;
            WAIT_DONE:         nxt = i2c_done ? EVAL : WAIT_DONE;
            EVAL: begin
                if (host_mode) begin
                    nxt = IDLE;
                end else if (nack_q) begin
                    retry_inc = retry < RETRY_MAX;
                    fail = !retry_inc;
                    nxt = retry_inc ? reissue : FINISH;
                end else if (op == OP_READ_CHECK && rdata_q != ent[VAL_HI:VAL_LO]) begin
                    poll_inc = poll < POLL_LAST;
                    fail = !poll_inc;
                    nxt = poll_inc ? DELAY : FINISH;
                end else begin
                    fail = index == LAST;
                    adv = !fail;
                    nxt = fail ? FINISH : FETCH;
                end
            end
            DELAY: begin
                if (dly > 32'd1) begin
                    nxt = DELAY;
                end else if (op == OP_READ_CHECK) begin
                    nxt = reissue;
                end else begin
                    fail = index == LAST;
                    adv = !fail;
                    nxt = fail ? FINISH : FETCH;
                end
            end
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
            retry <= '0;
            poll <= '0;
            dly <= '0;
            tmo <= '0;
            rdata_q <= '0;
            nack_q <= 1'b0;
            host_mode <= 1'b0;
            auto_pend <= AUTO_START != 0;
            init_done <= 1'b0;
            error <= 1'b0;
            error_index <= '0;
            i2c_chip_addr <= '0;
            i2c_reg_addr <= '0;
            i2c_value <= '0;
            i2c_is_read <= 1'b0;
        end else begin
            state <= nxt;
            tmo <= state == WAIT_START ? tmo + 2'd1 : 2'd0;
            if (state == IDLE && go) begin
                auto_pend <= 1'b0;
                host_mode <= 1'b0;
                init_done <= 1'b0;
                error <= 1'b0;
                index <= '0;
                retry <= '0;
                poll <= '0;
            end
            // command fields stay latched from ISSUE through EVAL
            if (nxt == HOST_ISSUE) begin
                host_mode <= 1'b1;
                i2c_chip_addr <= host_chip_addr;
                i2c_reg_addr <= host_reg_addr;
                i2c_value <= host_value;
                i2c_is_read <= host_is_read;
            end
            if (nxt == ISSUE) begin
                i2c_chip_addr <= ent[CHIP_HI:CHIP_LO];
                i2c_reg_addr <= ent[REG_HI:REG_LO];
                i2c_value <= ent[VAL_HI:VAL_LO];
                i2c_is_read <= op == OP_READ_CHECK;
            end
            if (state == WAIT_START && nxt == EVAL) nack_q <= 1'b1;
            if (state == WAIT_DONE && i2c_done) begin
                rdata_q <= i2c_data;
                nack_q <= i2c_ack_error;
            end
            if (state == DECODE && op == OP_END) init_done <= 1'b1;
            if (state == DECODE && op == OP_DELAY) dly <= {16'd0, ent[REG_HI:VAL_LO]} * UNIT;
            else if (poll_inc) dly <= UNIT;
            else if (state == DELAY) dly <= dly - 32'd1;
            if (retry_inc) retry <= retry + 16'd1;
            if (poll_inc) poll <= poll + 16'd1;
            if (adv) begin
                index <= index + IDX_W'(1);
                retry <= '0;
                poll <= '0;
            end
            if (fail) begin
                error <= 1'b1;
                error_index <= index;
            end
        end
    end
endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer: directed bench with an I2C block responder that can NACK
// a chosen register and return stale hot-plug status for a number of polls.
module tb_i2c_init_sequencer;
    localparam int DU = 8;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic host_req = 1'b0, host_is_read = 1'b0;
    logic [6:0] host_chip_addr = 7'h00;
    logic [7:0] host_reg_addr = 8'h00, host_value = 8'h00;
    logic busy, init_done, error, host_ack, host_nack, i2c_enable, i2c_is_read;
    logic [5:0] error_index;
    logic [7:0] host_rdata, i2c_reg_addr, i2c_value;
    logic [6:0] i2c_chip_addr;
    logic [7:0] i2c_data = 8'h00;
    logic i2c_done = 1'b1, i2c_ack_error = 1'b0;
    int cyc = 0, n_en = 0, mcnt = 0, seen_n = 0, seen42 = 0;
    logic pend_nack = 1'b0;
    logic [7:0] pend_data = 8'h00;
    logic [23:0] e_bits [256];
    int e_cyc [256];
    logic [7:0] nack_reg = 8'h00;
    int nack_cnt = 0, nack_base = 0, poll_zero = 0, poll_base = 0;
    int total = 0, bad = 0, b = 0, n = 0;

    i2c_init_sequencer #(.DELAY_UNIT(DU)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .init_done(init_done),
        .error(error), .error_index(error_index), .host_req(host_req),
        .host_is_read(host_is_read), .host_chip_addr(host_chip_addr),
        .host_reg_addr(host_reg_addr), .host_value(host_value), .host_ack(host_ack),
        .host_rdata(host_rdata), .host_nack(host_nack), .i2c_chip_addr(i2c_chip_addr),
        .i2c_reg_addr(i2c_reg_addr), .i2c_value(i2c_value), .i2c_enable(i2c_enable),
        .i2c_is_read(i2c_is_read), .i2c_data(i2c_data), .i2c_done(i2c_done),
        .i2c_ack_error(i2c_ack_error)
    );

    always #5 clk = ~clk;

    // responder: done drops the cycle after enable, rises 3 cycles later with the reply
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (i2c_enable) begin
            e_bits[n_en[7:0]] <= {i2c_is_read, i2c_chip_addr, i2c_reg_addr, i2c_value};
            e_cyc[n_en[7:0]] <= cyc;
            n_en <= n_en + 1;
        end
        if (i2c_enable && i2c_done) begin
            i2c_done <= 1'b0;
            mcnt <= 2;
            pend_nack <= i2c_reg_addr == nack_reg && seen_n - nack_base < nack_cnt;
            if (i2c_reg_addr == nack_reg) seen_n <= seen_n + 1;
            if (i2c_reg_addr == 8'h42) seen42 <= seen42 + 1;
            pend_data <= i2c_reg_addr != 8'h42 ? 8'hA5 : (seen42 - poll_base < poll_zero) ? 8'h00 : 8'h60;
        end else if (!i2c_done) begin
            if (mcnt == 0) begin
                i2c_done <= 1'b1;
                i2c_data <= pend_data;
                i2c_ack_error <= pend_nack;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_ack(input string tag);
        int k = 0;
        while (!host_ack && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(host_ack), 32'd1);
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({init_done, error, host_ack, host_nack, i2c_enable, i2c_is_read}), 32'd0);
        chk("rst_fields", 32'({i2c_chip_addr, i2c_reg_addr, i2c_value, host_rdata}), 32'd0);
        chk("rst_eidx", 32'(error_index), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("auto_start_busy", 32'(busy), 32'd1);
        wait_idle("s1_idle");
        chk("s1_count", 32'(n_en), 32'd10);
        chk("s1_en0", 32'(e_bits[0]), 32'({1'b0, 7'h39, 8'h41, 8'h10}));
        chk("s1_en1", 32'(e_bits[1]), 32'({1'b0, 7'h39, 8'h98, 8'h03}));
        chk("s1_en2", 32'(e_bits[2]), 32'({1'b1, 7'h39, 8'h42, 8'h60}));
        chk("s1_en9", 32'(e_bits[9]), 32'({1'b0, 7'h39, 8'hAF, 8'h06}));
        chk("s1_write_gap", 32'(e_cyc[1] - e_cyc[0]), 32'd8);
        chk("s1_delay_gap", 32'(e_cyc[3] - e_cyc[2]), 32'(10 + 2 * DU));
        chk("s1_flags", 32'({init_done, error}), 32'b10);

        nack_reg = 8'h41;
        nack_base = seen_n;
        nack_cnt = 2;
        b = n_en;
        pulse_start();
        chk("s2_done_cleared", 32'(init_done), 32'd0);
        wait_idle("s2_idle");
        chk("s2_count", 32'(n_en - b), 32'd12);
        chk("s2_try2", 32'(e_bits[b + 1]), 32'({1'b0, 7'h39, 8'h41, 8'h10}));
        chk("s2_try3", 32'(e_bits[b + 2]), 32'({1'b0, 7'h39, 8'h41, 8'h10}));
        chk("s2_next", 32'(e_bits[b + 3]), 32'({1'b0, 7'h39, 8'h98, 8'h03}));
        chk("s2_retry_gap", 32'(e_cyc[b + 1] - e_cyc[b]), 32'd6);
        chk("s2_flags", 32'({init_done, error}), 32'b10);

        nack_reg = 8'h98;
        nack_base = seen_n;
        nack_cnt = 4;
        b = n_en;
        pulse_start();
        wait_idle("s3_idle");
        chk("s3_count", 32'(n_en - b), 32'd5);
        chk("s3_flags", 32'({init_done, error}), 32'b01);
        chk("s3_eidx", 32'(error_index), 32'd1);
        repeat (20) @(negedge clk);
        chk("s3_quiet", 32'(n_en - b), 32'd5);
        nack_cnt = 0;

        poll_base = seen42;
        poll_zero = 2;
        b = n_en;
        pulse_start();
        wait_idle("s4_idle");
        chk("s4_count", 32'(n_en - b), 32'd12);
        chk("s4_poll3", 32'(e_bits[b + 4]), 32'({1'b1, 7'h39, 8'h42, 8'h60}));
        chk("s4_gap1", 32'(e_cyc[b + 3] - e_cyc[b + 2]), 32'(6 + DU));
        chk("s4_gap2", 32'(e_cyc[b + 4] - e_cyc[b + 3]), 32'(6 + DU));
        chk("s4_after", 32'(e_bits[b + 5]), 32'({1'b0, 7'h39, 8'h9A, 8'hE0}));
        chk("s4_flags", 32'({init_done, error}), 32'b10);
        poll_zero = 0;

        host_chip_addr = 7'h39;
        host_reg_addr = 8'h3E;
        host_value = 8'h00;
        host_is_read = 1'b1;
        b = n_en;
        @(negedge clk);
        host_req = 1'b1;
        wait_ack("s5_ack");
        chk("s5_rdata", 32'(host_rdata), 32'hA5);
        chk("s5_nack", 32'(host_nack), 32'd0);
        host_req = 1'b0;
        chk("s5_cmd", 32'(e_bits[b]), 32'({1'b1, 7'h39, 8'h3E, 8'h00}));
        @(negedge clk);
        chk("s5_ack_pulse", 32'(host_ack), 32'd0);
        chk("s5_count", 32'(n_en - b), 32'd1);

        nack_reg = 8'h3E;
        nack_base = seen_n;
        nack_cnt = 1;
        b = n_en;
        host_req = 1'b1;
        wait_ack("s5n_ack");
        chk("s5n_nack", 32'(host_nack), 32'd1);
        host_req = 1'b0;
        @(negedge clk);
        chk("s5n_no_retry", 32'(n_en - b), 32'd1);
        nack_cnt = 0;

        host_is_read = 1'b0;
        host_reg_addr = 8'hAF;
        host_value = 8'h04;
        b = n_en;
        @(negedge clk);
        start = 1'b1;
        host_req = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ack("s5b_ack");
        chk("s5b_seq_first", 32'(init_done), 32'd1);
        chk("s5b_nack", 32'(host_nack), 32'd0);
        host_req = 1'b0;
        chk("s5b_first_cmd", 32'(e_bits[b]), 32'({1'b0, 7'h39, 8'h41, 8'h10}));
        chk("s5b_host_cmd", 32'(e_bits[b + 10]), 32'({1'b0, 7'h39, 8'hAF, 8'h04}));
        chk("s5b_count", 32'(n_en - b), 32'd11);
        @(negedge clk);

        b = n_en;
        pulse_start();
        n = 0;
        while (n_en == b && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("s6_first_enable", 32'(n_en - b), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("s6_rst_busy", 32'({busy, i2c_enable, host_ack}), 32'd0);
        chk("s6_rst_fields", 32'({i2c_chip_addr, i2c_reg_addr, i2c_value}), 32'd0);
        chk("s6_rst_flags", 32'({init_done, error, i2c_is_read}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        b = n_en;
        @(negedge clk);
        chk("s6_restart_busy", 32'(busy), 32'd1);
        wait_idle("s6_idle");
        chk("s6_first_cmd", 32'(e_bits[b]), 32'({1'b0, 7'h39, 8'h41, 8'h10}));
        chk("s6_count", 32'(n_en - b), 32'd10);
        chk("s6_flags", 32'({init_done, error}), 32'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Drives the I2C register-access block (chip_addr/reg_addr/value/enable/is_read in; data/done/ack_error out) that configures the HDMI transmitter.
- Walks a command table of register writes, read-checks and delays after power-up or on a start request.
- Retries NACKed transfers.
- Arbitrates a single host request port (menu/OSD register tweaks) onto the same I2C block when the sequence is not running.

Parameters:
- TABLE_DEPTH, 64, number of command table entries; index width is clog2(TABLE_DEPTH).
- DELAY_UNIT, 27_000, clk cycles per delay unit (1 ms at 27 MHz).
- MAX_RETRY, 3, retries after a NACK before an entry is declared failed.
- POLL_LIMIT, 255, READ_CHECK attempts before an entry is declared failed.
- AUTO_START, 1, when 1 the sequence starts on the first cycle after reset release.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- start  in  1  pulse; (re)runs the table from entry 0 when IDLE
- busy  out  1  high while a sequence or host transfer is in progress
- init_done  out  1  sticky; set when END is reached without error, cleared on start
- error  out  1  sticky; set on retry/poll exhaustion, cleared on start
- error_index  out  6  table index of the failing entry
- host_req  in  1  level; host transfer request
- host_is_read  in  1  host read (1) / write (0)
- host_chip_addr  in  7  host target device
- host_reg_addr  in  8  host register
- host_value  in  8  host write data
- host_ack  out  1  one-cycle pulse on host transfer completion
- host_rdata  out  8  read data, valid with host_ack
- host_nack  out  1  valid with host_ack; transfer ended with ack_error
- i2c_chip_addr  out  7  to the I2C block chip_addr
- i2c_reg_addr  out  8  to the I2C block reg_addr
- i2c_value  out  8  to the I2C block value
- i2c_enable  out  1  to the I2C block enable
- i2c_is_read  out  1  to the I2C block is_read
- i2c_data  in  8  from the I2C block data
- i2c_done  in  1  from the I2C block done
- i2c_ack_error  in  1  from the I2C block ack_error

Behaviour:
- Reset values: all outputs 0, state IDLE, index 0, retry and poll counters 0. Reset mid-transfer abandons the transfer; the I2C block is not reset by this block.
- Table entry is 25 bits: op[1:0], chip[6:0], reg[7:0], val[7:0].
  - op WRITE=0
  - READ_CHECK=1: poll until data==val
  - DELAY=2: {reg,val} = 16-bit unit count
  - END=3
- ROM read latency is 1 cycle.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_START, WAIT_DONE, EVAL, DELAY, HOST_ISSUE, FINISH.
- IDLE:
  - start (or the first post-reset cycle when AUTO_START=1) -> clear init_done/error, index=0, FETCH.
  - Otherwise host_req -> HOST_ISSUE.
  - start and host_req in the same cycle: start wins; host_req stays pending.
- FETCH -> DECODE (1 cycle). DECODE:
  - WRITE/READ_CHECK -> ISSUE
  - DELAY -> DELAY, load counter = count*DELAY_UNIT; count 0 takes 1 cycle
  - END -> FINISH, set init_done
- ISSUE and HOST_ISSUE:
  - Only entered with i2c_done=1.
  - Drive addr/reg/value/is_read and pulse i2c_enable for exactly 1 cycle, then WAIT_START.
- WAIT_START: wait for i2c_done=0, then WAIT_DONE. A timeout of 4 cycles without done falling -> treat as NACK.
- Hold i2c_is_read and the address/value outputs stable from ISSUE until EVAL. The I2C block samples is_read mid-transfer.
- WAIT_DONE: on i2c_done=1, capture i2c_data and i2c_ack_error, then EVAL.
- EVAL for a table entry:
  - NACK and retry<MAX_RETRY -> retry++, ISSUE.
  - NACK and retries exhausted -> error=1, error_index=index, FINISH.
  - READ_CHECK with mismatch -> poll++, re-issue after a 1-unit DELAY; poll exhaustion -> error as above.
  - Otherwise index++, counters cleared, FETCH.
  - Index wrap past TABLE_DEPTH-1 without END -> error with error_index=TABLE_DEPTH-1.
- EVAL for a host transfer: host_ack=1 for 1 cycle with host_rdata and host_nack, no retry, then IDLE.
  - Requester must drop host_req the cycle after host_ack, otherwise a new transfer starts.
- FINISH -> IDLE (1 cycle).
- busy = state != IDLE.
- start while busy is ignored.
- host_req is never served while a sequence runs.

Decomposition:
- Shared package i2c_seq_pkg holds:
  - op encodings OP_WRITE, OP_READ_CHECK, OP_DELAY, OP_END
  - ENTRY_W=25 and field slice constants
  - state encoding
- Sub-module i2c_init_rom: synchronous ROM with addr in, 25-bit entry out, 1-cycle latency, holding the HDMI transmitter init table.

Test Plan:
- Table {WRITE 0x39/0x41/0x10, WRITE 0x39/0x98/0x03, END}; I2C model ACKs -> two enable pulses with correct fields, init_done=1, error=0, busy falls.
- Model NACKs the first 2 attempts of entry 0, then ACKs -> 3 enable pulses for entry 0, init_done=1.
- Model NACKs 4 times at entry 1 -> error=1, error_index=1, init_done=0, no further enables.
- READ_CHECK 0x39/0x42/0x60, model returns 0x00 twice then 0x60 -> 3 reads, 2 inter-poll delays of DELAY_UNIT cycles each, sequence continues.
- Sequence done, host_req read 0x39/0x3E, model returns 0xA5 -> one host_ack with host_rdata=0xA5, host_nack=0; start and host_req in the same cycle -> sequence runs first, host served after.
- Assert reset during WAIT_DONE -> all outputs 0 immediately; after release with AUTO_START=1, table restarts at index 0.
